// File: rtl/bht_update_unit_if.sv
// Predictor-table write port between the update unit and the BHT/BTB tables.
// valid/ready: a request transfers on any rising edge where UpdValid and
// UpdReady are both 1; while UpdValid & ~UpdReady the fields are held stable.
interface bht_update_unit_if #(
   parameter int TABLE_LEN = 4
);
   logic                 UpdValid;
   logic                 UpdReady;
   logic [TABLE_LEN-1:0] UpdIdx;
   logic [31:0]          UpdTag;
   logic [31:0]          UpdTarget;
   logic                 UpdTaken;
   logic                 UpdAlloc;

   modport master (
      output UpdValid, UpdIdx, UpdTag, UpdTarget, UpdTaken, UpdAlloc,
      input  UpdReady
   );

   modport slave (
      input  UpdValid, UpdIdx, UpdTag, UpdTarget, UpdTaken, UpdAlloc,
      output UpdReady
   );
endinterface

// File: rtl/bht_update_unit.sv
// Execute-stage branch resolution: flags mispredicts and redirects fetch in
// the same cycle, queues predictor-table updates in a small FIFO drained over
// the table write port, and keeps saturating performance counters.
module bht_update_unit #(
   parameter int TABLE_LEN  = 4,
   parameter int FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ValidE,
   input  logic        StallE,
   input  logic [31:0] PCE,
   input  logic        PredE,
   input  logic [31:0] NPC_PredE,
   input  logic        BranchE,
   input  logic [31:0] BrNPC,
   output logic        MispredE,
   output logic [31:0] RedirectPC,
   bht_update_unit_if.master upd,
   output logic [31:0] BrCnt,
   output logic [31:0] MispredCnt,
   output logic [31:0] DropCnt
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

   // Queue storage; the head slot is read straight out of these registers.
   logic [TABLE_LEN-1:0] idx_q    [FIFO_DEPTH];
   logic [31:0]          tag_q    [FIFO_DEPTH];
   logic [31:0]          target_q [FIFO_DEPTH];
   logic                 taken_q  [FIFO_DEPTH];
   logic                 alloc_q  [FIFO_DEPTH];

   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count;

   logic fire;
   logic mispredict;
   logic full;
   logic pop;
   logic do_push;
   logic drop;

   // Resolution: a stalled instruction is only evaluated in its final cycle.
   always_comb begin
      fire       = ValidE & ~StallE;
      mispredict = (PredE != BranchE) | (PredE & BranchE & (NPC_PredE != BrNPC));
      MispredE   = fire & mispredict;
      RedirectPC = BranchE ? BrNPC : (PCE + 32'd4);
   end

   // Queue control: a full queue still accepts a push when the head leaves.
   always_comb begin
      full    = (count == FULL_CNT);
      pop     = upd.UpdValid & upd.UpdReady;
      do_push = fire & (~full | pop);
      drop    = fire & full & ~pop;
   end

   // Head presentation from the register at the read pointer.
   always_comb begin
      upd.UpdValid  = (count != '0);
      upd.UpdIdx    = idx_q[rd_ptr];
      upd.UpdTag    = tag_q[rd_ptr];
      upd.UpdTarget = target_q[rd_ptr];
      upd.UpdTaken  = taken_q[rd_ptr];
      upd.UpdAlloc  = alloc_q[rd_ptr];
   end

   // Queue state: reset discards pending updates and clears the head fields.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            idx_q[i]    <= '0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            taken_q[i]  <= 1'b0;
            alloc_q[i]  <= 1'b0;
         end
      end else begin
         if (do_push) begin
            idx_q[wr_ptr]    <= PCE[TABLE_LEN+1:2];
            tag_q[wr_ptr]    <= PCE;
            target_q[wr_ptr] <= BrNPC;
            taken_q[wr_ptr]  <= BranchE;
            // Not-taken branches only decrement an existing entry.
            alloc_q[wr_ptr]  <= BranchE;
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !pop) begin
            count <= count + 1'b1;
         end else if (!do_push && pop) begin
            count <= count - 1'b1;
         end
      end
   end

   // Saturating performance counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         BrCnt      <= '0;
         MispredCnt <= '0;
         DropCnt    <= '0;
      end else begin
         if (fire && BrCnt != 32'hFFFF_FFFF) begin
            BrCnt <= BrCnt + 32'd1;
         end
         if (MispredE && MispredCnt != 32'hFFFF_FFFF) begin
            MispredCnt <= MispredCnt + 32'd1;
         end
         if (drop && DropCnt != 32'hFFFF_FFFF) begin
            DropCnt <= DropCnt + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_bht_update_unit.sv
// Directed bench for bht_update_unit: resolution, update packets, FIFO
// boundaries, stall gating and asynchronous reset.
module tb_bht_update_unit;

   logic        clk;
   logic        rst;
   logic        ValidE;
   logic        StallE;
   logic [31:0] PCE;
   logic        PredE;
   logic [31:0] NPC_PredE;
   logic        BranchE;
   logic [31:0] BrNPC;
   logic        MispredE;
   logic [31:0] RedirectPC;
   logic [31:0] BrCnt;
   logic [31:0] MispredCnt;
   logic [31:0] DropCnt;

   int n_cmp;
   int n_bad;

   bht_update_unit_if #(.TABLE_LEN(4)) upd_if ();

   bht_update_unit #(.TABLE_LEN(4), .FIFO_DEPTH(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .ValidE     (ValidE),
      .StallE     (StallE),
      .PCE        (PCE),
      .PredE      (PredE),
      .NPC_PredE  (NPC_PredE),
      .BranchE    (BranchE),
      .BrNPC      (BrNPC),
      .MispredE   (MispredE),
      .RedirectPC (RedirectPC),
      .upd        (upd_if.master),
      .BrCnt      (BrCnt),
      .MispredCnt (MispredCnt),
      .DropCnt    (DropCnt)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic s, input logic [31:0] pc,
                        input logic pred, input logic [31:0] npc_pred,
                        input logic br, input logic [31:0] br_npc);
      ValidE    = v;
      StallE    = s;
      PCE       = pc;
      PredE     = pred;
      NPC_PredE = npc_pred;
      BranchE   = br;
      BrNPC     = br_npc;
      #1;
   endtask

   task automatic check_counts(input string tag, input logic [31:0] br,
                               input logic [31:0] mp, input logic [31:0] dr);
      check({tag, "_brcnt"}, BrCnt, br);
      check({tag, "_mpcnt"}, MispredCnt, mp);
      check({tag, "_dropcnt"}, DropCnt, dr);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b0;
      upd_if.UpdReady = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      tick();

      // reset state
      check("rst_updvalid", {31'b0, upd_if.UpdValid}, 32'd0);
      check("rst_tag", upd_if.UpdTag, 32'h0);
      check("rst_target", upd_if.UpdTarget, 32'h0);
      check("rst_idx", {28'b0, upd_if.UpdIdx}, 32'd0);
      check_counts("rst", 32'd0, 32'd0, 32'd0);
      rst = 1'b1;
      tick();

      // taken branch predicted not-taken
      drive(1'b1, 1'b0, 32'h10, 1'b0, 32'h0, 1'b1, 32'h40);
      check("t1_mispred", {31'b0, MispredE}, 32'd1);
      check("t1_redirect", RedirectPC, 32'h40);
      check("t1_no_bypass", {31'b0, upd_if.UpdValid}, 32'd0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      check("t1_updvalid", {31'b0, upd_if.UpdValid}, 32'd1);
      check("t1_idx", {28'b0, upd_if.UpdIdx}, 32'd4);
      check("t1_tag", upd_if.UpdTag, 32'h10);
      check("t1_target", upd_if.UpdTarget, 32'h40);
      check("t1_taken", {31'b0, upd_if.UpdTaken}, 32'd1);
      check("t1_alloc", {31'b0, upd_if.UpdAlloc}, 32'd1);
      check_counts("t1", 32'd1, 32'd1, 32'd0);
      upd_if.UpdReady = 1'b1;
      tick();
      upd_if.UpdReady = 1'b0;
      check("t1_drained", {31'b0, upd_if.UpdValid}, 32'd0);

      // wrong target, then correct target
      drive(1'b1, 1'b0, 32'h20, 1'b1, 32'h80, 1'b1, 32'h84);
      check("t2_mispred_tgt", {31'b0, MispredE}, 32'd1);
      check("t2_redirect", RedirectPC, 32'h84);
      tick();
      drive(1'b1, 1'b0, 32'h20, 1'b1, 32'h84, 1'b1, 32'h84);
      check("t2_hit", {31'b0, MispredE}, 32'd0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      check_counts("t2", 32'd3, 32'd2, 32'd0);
      check("t2_head_tag", upd_if.UpdTag, 32'h20);
      upd_if.UpdReady = 1'b1;
      tick();
      check("t2_second_valid", {31'b0, upd_if.UpdValid}, 32'd1);
      check("t2_second_target", upd_if.UpdTarget, 32'h84);
      tick();
      upd_if.UpdReady = 1'b0;
      check("t2_drained", {31'b0, upd_if.UpdValid}, 32'd0);

      // predicted taken, actually not taken, PC+4 wraps
      drive(1'b1, 1'b0, 32'hFFFF_FFFC, 1'b1, 32'h5, 1'b0, 32'h1234);
      check("t3_mispred", {31'b0, MispredE}, 32'd1);
      check("t3_redirect_wrap", RedirectPC, 32'h0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      check("t3_alloc", {31'b0, upd_if.UpdAlloc}, 32'd0);
      check("t3_taken", {31'b0, upd_if.UpdTaken}, 32'd0);
      check("t3_idx", {28'b0, upd_if.UpdIdx}, 32'hF);
      check("t3_tag", upd_if.UpdTag, 32'hFFFF_FFFC);
      check_counts("t3", 32'd4, 32'd3, 32'd0);
      upd_if.UpdReady = 1'b1;
      tick();
      upd_if.UpdReady = 1'b0;
      check("t3_drained", {31'b0, upd_if.UpdValid}, 32'd0);

      // three fires into a blocked 2-deep queue
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 32'h100 + 32'(4 * i), 1'b0, 32'h0, 1'b0, 32'h900);
         check($sformatf("t4_fire%0d_hit", i), {31'b0, MispredE}, 32'd0);
         tick();
      end
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      check_counts("t4", 32'd7, 32'd3, 32'd1);
      check("t4_head", upd_if.UpdTag, 32'h100);
      tick();
      check("t4_head_held", upd_if.UpdTag, 32'h100);
      check("t4_dropcnt_held", DropCnt, 32'd1);

      // full queue: push and pop in the same cycle
      upd_if.UpdReady = 1'b1;
      drive(1'b1, 1'b0, 32'h10C, 1'b0, 32'h0, 1'b0, 32'h900);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      check_counts("t5", 32'd8, 32'd3, 32'd1);
      check("t5_head_second", upd_if.UpdTag, 32'h104);
      tick();
      check("t5_tail_valid", {31'b0, upd_if.UpdValid}, 32'd1);
      check("t5_tail_tag", upd_if.UpdTag, 32'h10C);
      check("t5_tail_idx", {28'b0, upd_if.UpdIdx}, 32'd3);
      tick();
      upd_if.UpdReady = 1'b0;
      check("t5_drained", {31'b0, upd_if.UpdValid}, 32'd0);

      // stalled instruction evaluated only in its last cycle
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h300);
         check($sformatf("t6_stall%0d_mispred", i), {31'b0, MispredE}, 32'd0);
         tick();
      end
      drive(1'b1, 1'b0, 32'h200, 1'b0, 32'h0, 1'b1, 32'h300);
      check("t6_final_mispred", {31'b0, MispredE}, 32'd1);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      check_counts("t6", 32'd9, 32'd4, 32'd1);
      check("t6_queued", upd_if.UpdTag, 32'h200);

      // asynchronous reset with a pending update
      #2;
      rst = 1'b0;
      #1;
      check("t7_updvalid", {31'b0, upd_if.UpdValid}, 32'd0);
      check("t7_tag", upd_if.UpdTag, 32'h0);
      check_counts("t7", 32'd0, 32'd0, 32'd0);
      tick();
      rst = 1'b1;
      tick();
      check("t7_still_empty", {31'b0, upd_if.UpdValid}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
